// File: rtl/iob_ahb2axis.sv
// iob_ahb2axis: AHB subordinate that turns writes into out_axis beats (tlast at burst end) and serves reads from in_axis.
// Latency: a write beat shows on out_axis one cycle after its data phase (later while the following HTRANS is BUSY); reads are zero-cycle.
// Backpressure: out_axis_tready low stretches write data phases; in_axis_tvalid low stretches read data phases.
// Ports: clk_i/arst_n_i/cke_i; s_ahb_* AHB subordinate port; out_axis_* + out_addr_o write stream;
//        in_axis_* read stream; rd_addr_o address of the read currently in its data phase.
module iob_ahb2axis #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  s_ahb_sel_i,
  input  logic [ADDR_WIDTH-1:0] s_ahb_addr_i,
  input  logic [1:0]            s_ahb_trans_i,
  input  logic                  s_ahb_write_i,
  input  logic [2:0]            s_ahb_size_i,
  input  logic [2:0]            s_ahb_burst_i,
  input  logic [3:0]            s_ahb_prot_i,
  input  logic                  s_ahb_mastlock_i,
  input  logic [DATA_WIDTH-1:0] s_ahb_wdata_i,
  input  logic [STRB_WIDTH-1:0] s_ahb_wstrb_i,
  input  logic                  s_ahb_ready_i,
  output logic                  s_ahb_readyout_o,
  output logic                  s_ahb_resp_o,
  output logic [DATA_WIDTH-1:0] s_ahb_rdata_o,
  output logic [DATA_WIDTH-1:0] out_axis_tdata_o,
  output logic [STRB_WIDTH-1:0] out_axis_tkeep_o,
  output logic                  out_axis_tlast_o,
  output logic                  out_axis_tvalid_o,
  input  logic                  out_axis_tready_i,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  input  logic [DATA_WIDTH-1:0] in_axis_tdata_i,
  input  logic                  in_axis_tvalid_i,
  output logic                  in_axis_tready_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o
);

  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] FULL_SIZE    = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state_q, state_d;

  logic                  step;
  logic                  xfer;
  logic                  size_ok;
  logic                  addr_busy;
  logic                  addr_seq;
  logic                  wr_cap;
  logic                  beat_fire;

  logic                  beat_vld_q;
  logic                  beat_res_q;
  logic                  beat_last_q;
  logic [DATA_WIDTH-1:0] beat_data_q;
  logic [STRB_WIDTH-1:0] beat_keep_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic                  wr_first_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  // HBURST/HPROT/HMASTLOCK carry nothing this block acts on.
  logic unused_ok;
  assign unused_ok = ^{s_ahb_burst_i, s_ahb_prot_i, s_ahb_mastlock_i};

  // step: an edge at which the bus pipeline advances (address and data phase sampled).
  assign step      = cke_i & s_ahb_ready_i;
  assign xfer      = s_ahb_sel_i & s_ahb_trans_i[1];
  assign size_ok   = (s_ahb_size_i == FULL_SIZE);
  // HTRANS seen on the address bus decides whether the beat just written ends its burst.
  assign addr_busy = s_ahb_sel_i & (s_ahb_trans_i == TRANS_BUSY);
  assign addr_seq  = s_ahb_sel_i & (s_ahb_trans_i == TRANS_SEQ) & size_ok;
  assign wr_cap    = step & (state_q == ST_WRITE) & s_ahb_readyout_o;
  assign beat_fire = out_axis_tvalid_o & out_axis_tready_i;

  // State register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
    end else if (cke_i) begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (s_ahb_ready_i) begin
      if (!xfer) begin
        state_d = ST_IDLE;
      end else if (!size_ok) begin
        state_d = ST_ERR1;
      end else if (s_ahb_write_i) begin
        state_d = ST_WRITE;
      end else begin
        state_d = ST_READ;
      end
    end
  end

  // Outputs decoded from the data-phase state
  always_comb begin
    s_ahb_readyout_o = 1'b1;
    s_ahb_resp_o     = 1'b0;
    s_ahb_rdata_o    = '0;
    in_axis_tready_o = 1'b0;
    case (state_q)
      ST_WRITE: s_ahb_readyout_o = ~beat_vld_q | out_axis_tready_i;
      ST_READ: begin
        in_axis_tready_o = 1'b1;
        s_ahb_readyout_o = in_axis_tvalid_i;
        s_ahb_rdata_o    = in_axis_tdata_i;
      end
      ST_ERR1: begin
        s_ahb_readyout_o = 1'b0;
        s_ahb_resp_o     = 1'b1;
      end
      ST_ERR2: s_ahb_resp_o = 1'b1;
      default: ;
    endcase
  end

  // Beat register and address tracking
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      beat_vld_q  <= 1'b0;
      beat_res_q  <= 1'b0;
      beat_last_q <= 1'b0;
      beat_data_q <= '0;
      beat_keep_q <= '0;
      out_addr_q  <= '0;
      wr_first_q  <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
    end else if (cke_i) begin
      if (wr_cap) begin
        beat_vld_q  <= 1'b1;
        beat_data_q <= s_ahb_wdata_i;
        beat_keep_q <= s_ahb_wstrb_i;
        beat_res_q  <= ~addr_busy;
        beat_last_q <= ~addr_seq;
        // out_addr moves only when the burst's first beat enters the register,
        // so it always describes the beat on out_axis.
        if (wr_first_q) begin
          out_addr_q <= wr_addr_q;
        end
      end else begin
        // A BUSY after the last written beat leaves tlast open; keep sampling HTRANS.
        if (step && beat_vld_q && !beat_res_q) begin
          beat_res_q  <= ~addr_busy;
          beat_last_q <= ~addr_seq;
        end
        if (beat_fire) begin
          beat_vld_q <= 1'b0;
        end
      end

      if (step && xfer && size_ok) begin
        if (s_ahb_write_i) begin
          wr_first_q <= (s_ahb_trans_i == TRANS_NONSEQ);
          wr_addr_q  <= s_ahb_addr_i;
        end else begin
          rd_addr_q <= s_ahb_addr_i;
        end
      end
    end
  end

  assign out_axis_tvalid_o = beat_vld_q & beat_res_q;
  assign out_axis_tdata_o  = beat_data_q;
  assign out_axis_tkeep_o  = beat_keep_q;
  assign out_axis_tlast_o  = beat_last_q;
  assign out_addr_o        = out_addr_q;
  assign rd_addr_o         = rd_addr_q;

endmodule

// File: tb/tb_iob_ahb2axis.sv
// tb_iob_ahb2axis: directed bench for iob_ahb2axis acting as the only subordinate (HREADY = HREADYOUT).
// Drives AHB transfers one address phase at a time, records out_axis beats, feeds in_axis with gaps.
module tb_iob_ahb2axis;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n, cke, sel, hwrite, hready, readyout, hresp, mastlock;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot, hwstrb;
  logic [31:0] out_tdata, out_addr, in_tdata, rd_addr;
  logic [3:0]  out_tkeep;
  logic        out_tlast, out_tvalid, out_tready, in_tvalid, in_tready;

  assign hready = readyout;

  iob_ahb2axis dut (
    .clk_i             (clk),
    .arst_n_i          (arst_n),
    .cke_i             (cke),
    .s_ahb_sel_i       (sel),
    .s_ahb_addr_i      (haddr),
    .s_ahb_trans_i     (htrans),
    .s_ahb_write_i     (hwrite),
    .s_ahb_size_i      (hsize),
    .s_ahb_burst_i     (hburst),
    .s_ahb_prot_i      (hprot),
    .s_ahb_mastlock_i  (mastlock),
    .s_ahb_wdata_i     (hwdata),
    .s_ahb_wstrb_i     (hwstrb),
    .s_ahb_ready_i     (hready),
    .s_ahb_readyout_o  (readyout),
    .s_ahb_resp_o      (hresp),
    .s_ahb_rdata_o     (hrdata),
    .out_axis_tdata_o  (out_tdata),
    .out_axis_tkeep_o  (out_tkeep),
    .out_axis_tlast_o  (out_tlast),
    .out_axis_tvalid_o (out_tvalid),
    .out_axis_tready_i (out_tready),
    .out_addr_o        (out_addr),
    .in_axis_tdata_i   (in_tdata),
    .in_axis_tvalid_i  (in_tvalid),
    .in_axis_tready_o  (in_tready),
    .rd_addr_o         (rd_addr)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [31:0] a;
  } beat_t;

  beat_t       mon_q[$];
  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rd_gaps [3] = '{0, 2, 1};
  logic [31:0] rd_vals [3] = '{32'hA, 32'hB, 32'hC};

  always @(negedge clk) begin
    if (arst_n && out_tvalid && out_tready)
      mon_q.push_back(beat_t'{out_tdata, out_tkeep, out_tlast, out_addr});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One address phase (plus the data phase of the previous transfer, wd).
  // Returns the wait states seen and the read/resp/rd_addr values at completion.
  task automatic ahb_phase(input logic [1:0] trans, input logic [31:0] addr, input logic wr,
                           input logic [2:0] size, input logic [31:0] wd, output int waits,
                           output logic [31:0] rd, output logic rs, output logic [31:0] ra);
    logic done;
    done = 1'b0; waits = 0; rd = '0; rs = 1'b0; ra = '0;
    sel = 1'b1; htrans = trans; haddr = addr; hwrite = wr; hsize = size; hwdata = wd; hwstrb = 4'hF;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (hready) begin
        done = 1'b1; rd = hrdata; rs = hresp; ra = rd_addr;
      end else begin
        waits++;
      end
    end
    check_eq("hready_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_stream(input string tag);
    check_eq({tag, "_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      check_eq({tag, "_data"}, mon_q[i].d, exp_q[i].d);
      check_eq({tag, "_keep"}, 32'(mon_q[i].k), 32'(exp_q[i].k));
      check_eq({tag, "_last"}, 32'(mon_q[i].l), 32'(exp_q[i].l));
      check_eq({tag, "_addr"}, mon_q[i].a, exp_q[i].a);
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_tvalid"},   32'(out_tvalid), 32'd0);
    check_eq({tag, "_tlast"},    32'(out_tlast),  32'd0);
    check_eq({tag, "_tkeep"},    32'(out_tkeep),  32'd0);
    check_eq({tag, "_tdata"},    out_tdata,       32'd0);
    check_eq({tag, "_out_addr"}, out_addr,        32'd0);
    check_eq({tag, "_readyout"}, 32'(readyout),   32'd1);
    check_eq({tag, "_resp"},     32'(hresp),      32'd0);
    check_eq({tag, "_rdata"},    hrdata,          32'd0);
    check_eq({tag, "_in_tready"},32'(in_tready),  32'd0);
    check_eq({tag, "_rd_addr"},  rd_addr,         32'd0);
  endtask

  task automatic set_idle();
    sel = 1'b0; htrans = IDLE; haddr = '0; hwrite = 1'b0; hsize = 3'd2; hwdata = '0; hwstrb = 4'hF;
  endtask

  // 4-beat INCR write at 0x100 with data 1..4; optional 3-cycle tready stall while beat 2 is pending.
  task automatic wr4(input logic stall);
    int w; logic [31:0] rd, ra; logic rs;
    for (int i = 0; i <= 4; i++) begin
      if (stall && i == 3) begin
        out_tready = 1'b0;
        fork
          begin repeat (3) @(posedge clk); #1 out_tready = 1'b1; end
        join_none
      end
      ahb_phase((i == 0) ? NONSEQ : ((i == 4) ? IDLE : SEQ), 32'h100 + 32'(4 * i), 1'b1, 3'd2,
                32'(i), w, rd, rs, ra);
      check_eq(stall ? "wr_stall_waits" : "wr_waits", 32'(w), (stall && i == 3) ? 32'd3 : 32'd0);
    end
    drain(2);
    for (int i = 1; i <= 4; i++) exp_q.push_back(beat_t'{32'(i), 4'hF, (i == 4), 32'h100});
    check_stream(stall ? "wr4_stall" : "wr4");
  endtask

  task automatic axis_source();
    for (int i = 0; i < 3; i++) begin
      in_tvalid = 1'b0;
      repeat (rd_gaps[i]) begin @(posedge clk); #1; end
      in_tvalid = 1'b1;
      in_tdata  = rd_vals[i];
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (in_tready) break;
      end
      @(posedge clk); #1;
    end
    in_tvalid = 1'b0;
    in_tdata  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w; logic [31:0] rd, ra; logic rs;
    arst_n = 1'b0; cke = 1'b1; mastlock = 1'b0; hburst = 3'd1; hprot = 4'd3;
    set_idle();
    out_tready = 1'b1; in_tvalid = 1'b0; in_tdata = '0;
    drain(3);
    check_reset("reset");
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;

    // Plain burst, then same burst with tready stalled at beat 2
    wr4(1'b0);
    wr4(1'b1);

    // SEQ, BUSY x2, IDLE: last beat held until BUSY resolves
    ahb_phase(NONSEQ, 32'h300, 1'b1, 3'd2, 32'h0,  w, rd, rs, ra);
    ahb_phase(SEQ,    32'h304, 1'b1, 3'd2, 32'h11, w, rd, rs, ra);
    ahb_phase(BUSY,   32'h308, 1'b1, 3'd2, 32'h22, w, rd, rs, ra);
    check_eq("busy_hold1_tvalid", 32'(out_tvalid), 32'd0);
    ahb_phase(BUSY,   32'h308, 1'b1, 3'd2, 32'h22, w, rd, rs, ra);
    check_eq("busy_hold2_tvalid", 32'(out_tvalid), 32'd0);
    ahb_phase(IDLE,   32'h0,   1'b0, 3'd2, 32'h22, w, rd, rs, ra);
    check_eq("busy_res_tvalid", 32'(out_tvalid), 32'd1);
    check_eq("busy_res_tlast",  32'(out_tlast),  32'd1);
    check_eq("busy_res_tdata",  out_tdata,       32'h22);
    drain(2);
    exp_q.push_back(beat_t'{32'h11, 4'hF, 1'b0, 32'h300});
    exp_q.push_back(beat_t'{32'h22, 4'hF, 1'b1, 32'h300});
    check_stream("busy");

    // 3-beat read at 0x200 with tvalid gaps 0/2/1
    fork axis_source(); join_none
    ahb_phase(NONSEQ, 32'h200, 1'b0, 3'd2, 32'h0, w, rd, rs, ra);
    for (int i = 0; i < 3; i++) begin
      ahb_phase((i < 2) ? SEQ : IDLE, 32'h204 + 32'(4 * i), 1'b0, 3'd2, 32'h0, w, rd, rs, ra);
      check_eq("rd_waits", 32'(w), 32'(rd_gaps[i]));
      check_eq("rd_data",  rd, rd_vals[i]);
      check_eq("rd_addr",  ra, 32'h200 + 32'(4 * i));
      check_eq("rd_resp",  32'(rs), 32'd0);
    end
    #1;
    check_eq("rd_done_in_tready", 32'(in_tready), 32'd0);
    check_eq("rd_done_rdata",     hrdata,         32'd0);

    // Byte write: two-cycle ERROR, no beat
    ahb_phase(NONSEQ, 32'h400, 1'b1, 3'd0, 32'h0, w, rd, rs, ra);
    check_eq("err1_readyout", 32'(readyout), 32'd0);
    check_eq("err1_resp",     32'(hresp),    32'd1);
    ahb_phase(IDLE, 32'h0, 1'b0, 3'd2, 32'hDEAD, w, rd, rs, ra);
    check_eq("err_waits",  32'(w),  32'd1);
    check_eq("err2_resp",  32'(rs), 32'd1);
    check_eq("err_after_readyout", 32'(readyout), 32'd1);
    check_eq("err_after_resp",     32'(hresp),    32'd0);
    drain(2);
    check_stream("err");

    // Reset in the middle of a write burst with beat 2 pending
    ahb_phase(NONSEQ, 32'h500, 1'b1, 3'd2, 32'h0,  w, rd, rs, ra);
    ahb_phase(SEQ,    32'h504, 1'b1, 3'd2, 32'h51, w, rd, rs, ra);
    ahb_phase(SEQ,    32'h508, 1'b1, 3'd2, 32'h52, w, rd, rs, ra);
    out_tready = 1'b0;
    #1;
    check_eq("rst_pending_tvalid", 32'(out_tvalid), 32'd1);
    arst_n = 1'b0;
    #2;
    check_reset("midrst");
    set_idle();
    out_tready = 1'b1;
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(beat_t'{32'h51, 4'hF, 1'b0, 32'h500});
    check_stream("prerst");
    ahb_phase(NONSEQ, 32'h600, 1'b1, 3'd2, 32'h0,  w, rd, rs, ra);
    ahb_phase(SEQ,    32'h604, 1'b1, 3'd2, 32'h61, w, rd, rs, ra);
    ahb_phase(IDLE,   32'h0,   1'b0, 3'd2, 32'h62, w, rd, rs, ra);
    drain(2);
    exp_q.push_back(beat_t'{32'h61, 4'hF, 1'b0, 32'h600});
    exp_q.push_back(beat_t'{32'h62, 4'hF, 1'b1, 32'h600});
    check_stream("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
